// File: rtl/fullscreen_image_fader.sv
// Full-screen image renderer with frame-synchronous brightness fading.
//
// Stretches one of NUM_IMAGES low-resolution images (stored back-to-back in an
// external synchronous ROM + palette) across the visible VGA area and fades its
// brightness in and out, stepping the level only at the frame tick so a frame
// never shows two brightness levels.
//
// Ports:
//   vga_clk        pixel clock, all state on the rising edge
//   reset_n        synchronous active-low reset
//   DrawX, DrawY   current pixel coordinates from the VGA controller
//   blank          1 = visible region
//   img_sel        image index, latched when a fade-in starts from dark
//   start_fade_in  single-cycle fade-in request
//   start_fade_out single-cycle fade-out request
//   rom_addr       combinational ROM address for the current pixel
//   pix_*          palette colour, valid one cycle after rom_addr
//   red/green/blue registered, brightness-scaled output colour
//   busy           fade in progress
//   shown          image fully visible
//   fade_done      one-cycle pulse when a fade completes
module fullscreen_image_fader #(
  parameter int unsigned IMG_W           = 160,
  parameter int unsigned IMG_H           = 120,
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SCREEN_H        = 480,
  parameter int unsigned NUM_IMAGES      = 2,
  parameter int unsigned SEL_W           = 1,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned FADE_STEPS      = 16,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [SEL_W-1:0]  img_sel,
  input  logic              start_fade_in,
  input  logic              start_fade_out,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        pix_red,
  input  logic [3:0]        pix_green,
  input  logic [3:0]        pix_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              busy,
  output logic              shown,
  output logic              fade_done
);

  localparam int unsigned Shift = $clog2(FADE_STEPS);
  localparam int unsigned LvlW  = Shift + 1;
  localparam int unsigned ProdW = LvlW + 4;
  localparam int unsigned CntW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [LvlW-1:0] LvlMax  = LvlW'(FADE_STEPS);
  localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {StDark, StFadeIn, StShown, StFadeOut} state_e;

  state_e            state_q, state_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              done_q, done_d;
  logic              blank_d_q;
  logic [3:0]        red_q, red_d;
  logic [3:0]        green_q, green_d;
  logic [3:0]        blue_q, blue_d;

  logic              tick;
  logic              req_in;
  logic              req_out;

  // ---------------------------------------------------------------------------
  // Address generation: nearest-lower source pixel, image offset from sel_q
  // ---------------------------------------------------------------------------
  logic [31:0] x_src, y_row, img_base;

  always_comb begin
    x_src    = (32'(DrawX) * IMG_W) / SCREEN_W;
    y_row    = ((32'(DrawY) * IMG_H) / SCREEN_H) * IMG_W;
    img_base = 32'(sel_q) * IMG_W * IMG_H;
    rom_addr = ADDR_W'(img_base + x_src + y_row);
  end

  // ---------------------------------------------------------------------------
  // Fade state machine
  // ---------------------------------------------------------------------------
  // First cycle of the vertical blanking interval.
  assign tick    = (DrawX == 10'd0) && (DrawY == 10'(SCREEN_H));
  // A simultaneous pair of requests counts as a fade-in only.
  assign req_in  = start_fade_in;
  assign req_out = start_fade_out & ~start_fade_in;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;

    unique case (state_q)
      StDark: begin
        if (req_in) begin
          state_d = StFadeIn;
          sel_d   = img_sel;
          cnt_d   = '0;
        end
      end

      StFadeIn: begin
        // A request on a tick cycle wins; that tick is not counted.
        if (req_out) begin
          state_d = StFadeOut;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            level_d = level_q + LvlW'(1);
            if (level_d == LvlMax) begin
              state_d = StShown;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StShown: begin
        if (req_out) begin
          state_d = StFadeOut;
          cnt_d   = '0;
        end
      end

      StFadeOut: begin
        if (req_in) begin
          state_d = StFadeIn;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            level_d = level_q - LvlW'(1);
            if (level_d == '0) begin
              state_d = StDark;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: state_d = StDark;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Colour pipeline: palette data arrives one cycle after the address, so the
  // blank flag is delayed by one register to line up with it.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [LvlW-1:0] lvl);
    logic [ProdW-1:0] prod;
    prod = ProdW'(c) * ProdW'(lvl);
    return 4'(prod >> Shift);
  endfunction

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (blank_d_q) begin
      red_d   = scale(pix_red, level_q);
      green_d = scale(pix_green, level_q);
      blue_d  = scale(pix_blue, level_q);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q   <= StDark;
      level_q   <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      done_q    <= 1'b0;
      blank_d_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      blank_d_q <= blank;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign busy      = (state_q == StFadeIn) || (state_q == StFadeOut);
  assign shown     = (state_q == StShown);
  assign fade_done = done_q;

endmodule

// File: tb/tb_fullscreen_image_fader.sv
// Self-checking bench for fullscreen_image_fader: randomized pixels, positions
// and blanking checked against a tick-counting model of the fade.
module tb_fullscreen_image_fader;

  localparam int IMG_W    = 160;
  localparam int IMG_H    = 120;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int FS       = 16;
  localparam int FPS      = 2;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic [0:0]  img_sel = '0;
  logic        start_fade_in = 1'b0;
  logic        start_fade_out = 1'b0;
  logic [15:0] rom_addr;
  logic [3:0]  pix_red = '0;
  logic [3:0]  pix_green = '0;
  logic [3:0]  pix_blue = '0;
  logic [3:0]  red, green, blue;
  logic        busy, shown, fade_done;

  always #5 vga_clk = ~vga_clk;

  fullscreen_image_fader dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .img_sel       (img_sel),
    .start_fade_in (start_fade_in),
    .start_fade_out(start_fade_out),
    .rom_addr      (rom_addr),
    .pix_red       (pix_red),
    .pix_green     (pix_green),
    .pix_blue      (pix_blue),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .busy          (busy),
    .shown         (shown),
    .fade_done     (fade_done)
  );

  int total = 0;
  int bad   = 0;

  // Model: state 0 dark, 1 fading in, 2 shown, 3 fading out. The level during a
  // fade is the level at the fade's start plus/minus whole steps of ticks seen.
  int m_state, m_level, m_base, m_ticks, m_sel, m_bd;
  int m_r, m_g, m_b;
  bit m_done;
  int last_x, last_y;

  wire [14:0] obs = {red, green, blue, busy, shown, fade_done};

  function automatic logic [14:0] exp_vec();
    return {4'(m_r), 4'(m_g), 4'(m_b), (m_state == 1 || m_state == 3), (m_state == 2), m_done};
  endfunction

  function automatic logic [15:0] exp_addr(input int sel, input int x, input int y);
    return 16'(sel * IMG_W * IMG_H + (x * IMG_W) / SCREEN_W + ((y * IMG_H) / SCREEN_H) * IMG_W);
  endfunction

  task automatic step(input bit rst_n, input int x, input int y, input bit bl, input int sel,
                      input bit fi, input bit fo, input int pr, input int pg, input int pb);
    bit tick, rin, rout;
    reset_n = rst_n; DrawX = 10'(x); DrawY = 10'(y); blank = bl; img_sel = 1'(sel);
    start_fade_in = fi; start_fade_out = fo;
    pix_red = 4'(pr); pix_green = 4'(pg); pix_blue = 4'(pb);
    last_x = x; last_y = y;
    @(posedge vga_clk);
    if (!rst_n) begin
      m_state = 0; m_level = 0; m_base = 0; m_ticks = 0; m_sel = 0; m_bd = 0;
      m_r = 0; m_g = 0; m_b = 0; m_done = 0;
    end else begin
      m_r = m_bd != 0 ? (pr * m_level) / FS : 0;
      m_g = m_bd != 0 ? (pg * m_level) / FS : 0;
      m_b = m_bd != 0 ? (pb * m_level) / FS : 0;
      m_bd = int'(bl);
      m_done = 0;
      tick = (x == 0) && (y == SCREEN_H);
      rin  = fi && (m_state == 0 || m_state == 3);
      rout = fo && !fi && (m_state == 1 || m_state == 2);
      if (rin) begin
        if (m_state == 0) m_sel = sel;
        m_state = 1; m_base = m_level; m_ticks = 0;
      end else if (rout) begin
        m_state = 3; m_base = m_level; m_ticks = 0;
      end else if (tick && m_state == 1) begin
        m_ticks++;
        m_level = m_base + m_ticks / FPS;
        if (m_level == FS) begin m_state = 2; m_done = 1; end
      end else if (tick && m_state == 3) begin
        m_ticks++;
        m_level = m_base - m_ticks / FPS;
        if (m_level == 0) begin m_state = 0; m_done = 1; end
      end
    end
    #1;
    start_fade_in = 1'b0; start_fade_out = 1'b0;
  endtask

  // bl: 0 or 1 forces blank, anything else randomizes it.
  task automatic rand_step(input bit fi, input bit fo, input int bl);
    bit b;
    b = (bl == 0 || bl == 1) ? bit'(bl) : bit'($urandom_range(1, 0));
    step(1'b1, int'($urandom_range(639, 1)), int'($urandom_range(524, 0)), b,
         int'($urandom_range(1, 0)), fi, fo, int'($urandom_range(15, 0)),
         int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
  endtask

  task automatic tick_step(input bit fi, input bit fo);
    step(1'b1, 0, SCREEN_H, 1'b0, int'($urandom_range(1, 0)), fi, fo,
         int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
  endtask

  task automatic do_reset();
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== 15'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    for (int i = 0; i < 8; i++) begin
      rand_step(1'b0, 1'b0, 1);
      total++;
      if (obs !== 15'h0 || obs !== exp_vec()) begin
        bad++; $display("FAIL reset_dark_blank: got %h want %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_addr();
    do_reset();
    step(1'b1, 639, 479, 1'b1, 1, 1'b1, 1'b0, 0, 0, 0);
    total++;
    if (rom_addr !== 16'd38399 || rom_addr !== exp_addr(m_sel, 639, 479)) begin
      bad++; $display("FAIL addr_corner: got %0d want %0d", rom_addr, exp_addr(m_sel, 639, 479));
    end
    step(1'b1, 4, 4, 1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
    total++;
    if (rom_addr !== exp_addr(m_sel, 4, 4)) begin
      bad++; $display("FAIL addr_4_4: got %0d want %0d", rom_addr, exp_addr(m_sel, 4, 4));
    end
    for (int i = 0; i < 12; i++) begin
      rand_step(1'b0, 1'b0, 2);
      total++;
      if (rom_addr !== exp_addr(m_sel, last_x, last_y)) begin
        bad++;
        $display("FAIL addr_rand_sel1: got %0d want %0d", rom_addr, exp_addr(m_sel, last_x, last_y));
      end
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_step(1'b0, 1'b0, 2);
      total++;
      if (rom_addr !== exp_addr(m_sel, last_x, last_y)) begin
        bad++;
        $display("FAIL addr_rand_sel0: got %0d want %0d", rom_addr, exp_addr(m_sel, last_x, last_y));
      end
    end
  endtask

  task automatic test_fade_in();
    int dones = 0;
    do_reset();
    rand_step(1'b1, 1'b0, 2);
    for (int t = 0; t < 32; t++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) tick_step(1'b0, 1'b0);
        else rand_step(1'b0, 1'b0, 2);
        if (fade_done === 1'b1) dones++;
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL fade_in_cycle t=%0d: got %h want %h", t, obs, exp_vec());
        end
      end
    end
    total++;
    if (shown !== 1'b1 || busy !== 1'b0 || dones != 1) begin
      bad++; $display("FAIL fade_in_end: got shown=%b busy=%b dones=%0d want 1 0 1", shown, busy, dones);
    end
    step(1'b1, 7, 7, 1'b1, 0, 1'b0, 1'b0, 15, 15, 15);
    step(1'b1, 8, 7, 1'b1, 0, 1'b0, 1'b0, 15, 15, 15);
    total++;
    if ({red, green, blue} !== 12'hFFF || obs !== exp_vec()) begin
      bad++; $display("FAIL full_bright: got %h want fff", {red, green, blue});
    end
  endtask

  task automatic test_scale();
    do_reset();
    rand_step(1'b1, 1'b0, 2);
    for (int t = 0; t < 16; t++) begin
      rand_step(1'b0, 1'b0, 2);
      tick_step(1'b0, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL scale_ramp t=%0d: got %h want %h", t, obs, exp_vec());
      end
    end
    step(1'b1, 5, 5, 1'b1, 0, 1'b0, 1'b0, 15, 15, 15);
    step(1'b1, 6, 5, 1'b1, 0, 1'b0, 1'b0, 15, 8, 0);
    total++;
    if ({red, green, blue} !== 12'h740 || obs !== exp_vec()) begin
      bad++; $display("FAIL scale_lvl8_F: got %h want 740", {red, green, blue});
    end
    step(1'b1, 7, 5, 1'b0, 0, 1'b0, 1'b0, 4, 3, 1);
    total++;
    if ({red, green, blue} !== 12'h210 || obs !== exp_vec()) begin
      bad++; $display("FAIL scale_lvl8_4: got %h want 210", {red, green, blue});
    end
    step(1'b1, 8, 5, 1'b1, 0, 1'b0, 1'b0, 15, 15, 15);
    total++;
    if ({red, green, blue} !== 12'h000 || obs !== exp_vec()) begin
      bad++; $display("FAIL scale_blanked: got %h want 000", {red, green, blue});
    end
  endtask

  task automatic test_fade_out();
    int dones = 0;
    do_reset();
    rand_step(1'b1, 1'b0, 2);
    for (int t = 0; t < 20; t++) begin
      rand_step(1'b0, 1'b0, 2);
      tick_step(1'b0, 1'b0);
    end
    rand_step(1'b0, 1'b1, 2);
    total++;
    if (busy !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL fade_out_start: got %h want %h", obs, exp_vec());
    end
    for (int t = 0; t < 22; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 2) tick_step(1'b0, 1'b0);
        else rand_step(1'b0, 1'b0, 2);
        if (fade_done === 1'b1) dones++;
        total++;
        if (obs !== exp_vec() || rom_addr !== exp_addr(m_sel, last_x, last_y)) begin
          bad++;
          $display("FAIL fade_out_cycle t=%0d: got %h addr %0d want %h addr %0d", t, obs,
                   rom_addr, exp_vec(), exp_addr(m_sel, last_x, last_y));
        end
      end
    end
    total++;
    if (busy !== 1'b0 || shown !== 1'b0 || dones != 1) begin
      bad++; $display("FAIL fade_out_end: got busy=%b shown=%b dones=%0d want 0 0 1", busy, shown, dones);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_step(1'b1, 1'b0, 2);
    for (int t = 0; t < 32; t++) begin
      rand_step(1'b0, 1'b0, 2);
      tick_step(1'b0, 1'b0);
    end
    total++;
    if (shown !== 1'b1) begin
      bad++; $display("FAIL reset_mid_shown: got %b want 1", shown);
    end
    rand_step(1'b0, 1'b1, 1);
    for (int t = 0; t < 7; t++) begin
      rand_step(1'b0, 1'b0, 1);
      tick_step(1'b0, 1'b0);
    end
    step(1'b1, 3, 3, 1'b1, 0, 1'b0, 1'b0, 15, 15, 15);
    step(1'b0, 4, 3, 1'b1, 0, 1'b0, 1'b0, 15, 15, 15);
    total++;
    if (obs !== 15'h0) begin
      bad++; $display("FAIL reset_mid_abort: got %h want 0", obs);
    end
    for (int i = 0; i < 6; i++) begin
      rand_step(1'b0, 1'b0, 1);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL reset_mid_after: got %h want %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    rand_step(1'b1, 1'b1, 2);
    total++;
    if (busy !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL prio_both_dark: got %h want %h", obs, exp_vec());
    end
    for (int t = 0; t < 32; t++) begin
      rand_step(1'b0, 1'b0, 2);
      tick_step(1'b0, 1'b0);
    end
    rand_step(1'b1, 1'b1, 2);
    total++;
    if (shown !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL prio_both_shown: got %h want %h", obs, exp_vec());
    end
    tick_step(1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 2) tick_step(1'b0, 1'b0);
        else rand_step(1'b0, 1'b0, 2);
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL prio_out_cycle t=%0d: got %h want %h", t, obs, exp_vec());
        end
      end
    end
    tick_step(1'b1, 1'b0);
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 2) tick_step(1'b0, 1'b0);
        else rand_step(1'b0, 1'b0, 2);
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL prio_in_cycle t=%0d: got %h want %h", t, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr();
    test_fade_in();
    test_scale();
    test_fade_out();
    test_reset_mid();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
